fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction prefetch queue between the program counter and instruction memory, feeding the decode stage. It captures each fetched (PC, instruction) pair and presents pairs to decode in order. It applies backpressure to the PC through `in_ready` and discards all queued work on a branch redirect (`flush`).

## Interface

Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of 2 and at least 2.
- `ADDR_W`, default 64: PC width.
- `INSTR_W`, default 32: instruction width.

Ports:
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `reset`  in  1  Synchronous, active-low.
- `in_valid`  in  1  Fetched pair is present on `in_pc` / `in_instr`.
- `in_pc`  in  ADDR_W  PC of the fetched word (program counter `pc_out`).
- `in_instr`  in  INSTR_W  Instruction-memory data for `in_pc`.
- `in_ready`  out  1  Buffer can accept a push. Equals not-full; the PC holds while this is low.
- `out_valid`  out  1  Head entry is valid.
- `out_pc`  out  ADDR_W  PC of the head entry.
- `out_instr`  out  INSTR_W  Instruction of the head entry.
- `out_ready`  in  1  Decode accepts the head entry.
- `flush`  in  1  Branch taken / redirect. Empties the buffer.
- `count`  out  $clog2(DEPTH+1)  Current occupancy.
- `align_err`  out  1  Sticky flag: a push was attempted with a misaligned PC.

## Operation

- **Storage:** circular buffer of DEPTH entries `{pc, instr}`, with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits and a separate `count` register.
  - Full: `count == DEPTH`.
  - Empty: `count == 0`.
- **Push:** `in_valid && in_ready && !flush && in_pc[1:0] == 2'b00`. Writes `mem[wr_ptr]`; `wr_ptr` increments with natural wrap.
- **Misaligned push:** `in_valid && in_ready && !flush && in_pc[1:0] != 0`. The entry is dropped and `align_err` is set. `align_err` clears only on reset.
- **Pop:** `out_valid && out_ready && !flush`. `rd_ptr` increments with wrap.
- **Simultaneous push and pop:** `count` is unchanged; both pointers advance.
- **Full:** `in_ready = 0`, so no push occurs even if a pop happens in the same cycle. There is no full-bypass.
- **Empty:** `out_valid = 0`, so no pop occurs. A same-cycle push is not forwarded; there is no fall-through.
- **Flush (highest priority):** at the next edge, `count`, `wr_ptr` and `rd_ptr` become 0. Any same-cycle push and pop are discarded. `align_err` is unaffected.
- **Output masking:** `out_pc`/`out_instr` = `mem[rd_ptr]` when `out_valid`, else 0. Storage contents themselves are not reset.
- **Reset** (`reset == 0` at an edge): `count = 0`, pointers 0, `align_err = 0`. Resulting outputs:
  - `in_ready = 1`
  - `out_valid = 0`
  - `out_pc = 0`
  - `out_instr = 0`
- **Reset mid-operation:** identical to flush, and additionally clears `align_err`. Reset overrides flush, push and pop.

## Timing

- A push at edge N is visible at the outputs after edge N. Minimum latency from input to output is 1 cycle.
- `out_valid`, `in_ready`, `count`, `out_pc` and `out_instr` are combinational functions of registered state only. There is no combinational path from any input to any output.
- `out_valid` is `count != 0` and `in_ready` is `count != DEPTH`, both decoded from the `count` register.
- Steady-state throughput is 1 entry per cycle with simultaneous push and pop.
- After a flush edge: `out_valid = 0` and `in_ready = 1` in the following cycle. The first post-flush push appears one cycle after it is accepted.

## Structure

- **Shared package `fetch_pkg`:**
  - constants `ADDR_W = 64`, `INSTR_W = 32`
  - `typedef struct packed { logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr; } fetch_entry_t`
- The storage array is of type `fetch_entry_t`.
- **Sub-module `fetch_ptr`:** a wrapping $clog2(DEPTH)-bit pointer register with `inc` and `clr` inputs and synchronous active-low reset. It is instantiated twice, once for write and once for read.
- `count` update logic and output masking remain in `fetch_buffer`.

## Test plan

- **Reset / idle:** hold `reset = 0` for 2 cycles, then release → `count = 0`, `in_ready = 1`, `out_valid = 0`, `out_pc = 0`, `out_instr = 0`, `align_err = 0`.
- **Fill and backpressure:** push PCs 0x0, 0x4, 0x8, 0xC with `out_ready = 0` → after the 4th edge `count = 4` and `in_ready = 0`. A 5th push of 0x10 is ignored; the head stays 0x0.
- **Order and wrap:** hold `out_ready = 1` with continuous pushes 0x0 through 0x3C → outputs appear in order 0x0, 0x4, … 0x3C, each 1 cycle after its push. `count` stays at 1 and the pointers wrap at least 3 times.
- **Flush with concurrent push/pop:** with `count = 3`, assert `flush` together with `in_valid` (PC 0x100) and `out_ready` → next cycle `count = 0`, `out_valid = 0`. PC 0x100 never appears at the output.
- **Misaligned PC:** push PC 0x6 → `count` is unchanged and `align_err = 1`, staying high through a later flush. `align_err` clears only after reset.
- **Reset mid-operation:** with `count = 2`, pull `reset` low during a simultaneous push and pop → after the edge all state is at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and widths for the instruction fetch buffer.
//               Provides the default PC and instruction widths and the packed
//               storage entry type {pc, instr}.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_if
// Description : Handshake bundle between PC/instruction memory, the fetch
//               buffer and decode.
//   in_valid/in_pc/in_instr/in_ready : fetched pair in, backpressure out
//   out_valid/out_pc/out_instr/out_ready : head entry to decode
//   flush                               : branch redirect, empties buffer
//   modport master : fetch/decode side (drives in_*, out_ready, flush)
//   modport slave  : the buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_buffer_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) ();

  logic               in_valid;
  logic [ADDR_W-1:0]  in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               out_valid;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;
  logic               flush;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr
  );

endinterface : fetch_buffer_if
`default_nettype wire

// File: rtl/fetch_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ptr
// Description : Wrapping circular-buffer pointer. DEPTH is a power of two, so
//               the pointer wraps naturally on overflow.
//   clk    : clock
//   reset  : synchronous, active-low
//   inc_i  : advance pointer by one
//   clr_i  : return pointer to 0 (takes priority over inc_i)
//   ptr_o  : current pointer value, $clog2(DEPTH) bits
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ptr #(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     inc_i,
  input  wire logic                     clr_i,
  output      logic [$clog2(DEPTH)-1:0] ptr_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fetch_ptr
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Instruction prefetch queue between the PC and decode. Captures
//               (pc, instr) pairs in order, backpressures the PC when full,
//               and drops all queued work on flush. Misaligned pushes are
//               discarded and recorded in a sticky align_err flag.
//   clk       : clock
//   reset     : synchronous, active-low
//   bus       : fetch_buffer_if.slave handshake bundle
//   count     : current occupancy
//   align_err : sticky, set by a push attempt with pc[1:0] != 0
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH   = 4,   // power of two, >= 2
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  fetch_buffer_if.slave                   bus,
  output      logic [$clog2(DEPTH+1)-1:0] count,
  output      logic                       align_err
);

  import fetch_pkg::*;

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t mem_q [DEPTH];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             align_err_q;
  logic             align_err_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic w_in_ready;
  logic w_out_valid;
  logic w_try_push;
  logic w_push;
  logic w_misaligned;
  logic w_pop;

  // Status is decoded from the count register only, so no input reaches
  // any output combinationally.
  assign w_in_ready  = (count_q != FULL_CNT);
  assign w_out_valid = (count_q != '0);

  assign w_try_push   = bus.in_valid && w_in_ready && !bus.flush;
  assign w_push       = w_try_push && (bus.in_pc[1:0] == 2'b00);
  assign w_misaligned = w_try_push && (bus.in_pc[1:0] != 2'b00);
  assign w_pop        = w_out_valid && bus.out_ready && !bus.flush;

  fetch_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (w_push),
    .clr_i (bus.flush),
    .ptr_o (wr_ptr)
  );

  fetch_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (w_pop),
    .clr_i (bus.flush),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // align_err survives flush; only reset clears it.
  assign align_err_d = align_err_q | w_misaligned;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      align_err_q <= align_err_d;
    end
  end

  // Storage is intentionally not reset; stale contents are hidden by the
  // output mask below.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      mem_q[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? mem_q[rd_ptr].pc    : '0;
  assign bus.out_instr = w_out_valid ? mem_q[rd_ptr].instr : '0;
  assign count         = count_q;
  assign align_err     = align_err_q;

endmodule : fetch_buffer
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] count;
  logic       align_err;

  int n_checks = 0;
  int n_errors = 0;

  ent_t model_q[$];
  logic model_align;

  fetch_buffer_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .count     (count),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = model_q.size();
    chk("count",     64'(count),         64'(sz));
    chk("in_ready",  64'(bus.in_ready),  64'(sz < DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(sz > 0));
    chk("out_pc",    bus.out_pc,         (sz > 0) ? model_q[0].pc : 64'h0);
    chk("out_instr", 64'(bus.out_instr), (sz > 0) ? 64'(model_q[0].instr) : 64'h0);
    chk("align_err", 64'(align_err),     64'(model_align));
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic rn, input logic v, input logic [63:0] pc,
                       input logic [31:0] ins, input logic ordy, input logic fl);
    bit full, pop;
    reset         = rn;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    if (!rn) begin
      model_q.delete();
      model_align = 1'b0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      full = (model_q.size() == DEPTH);
      pop  = (model_q.size() > 0) && ordy;
      if (pop) void'(model_q.pop_front());
      if (v && !full) begin
        if (pc[1:0] == 2'b00) model_q.push_back('{pc: pc, instr: ins});
        else model_align = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b1, 1'b0, 64'h0, 32'h0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rpc;
    model_align = 1'b0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Reset / idle
    do_reset();
    idle(1'b0);

    // Fill and backpressure; fifth push is ignored
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 64'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    // Drain
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Order and wrap: continuous push with decode always ready
    do_reset();
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b1, 64'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    idle(1'b1);

    // Flush with concurrent push and pop at count 3
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 64'h200 + 64'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h100, 32'h1234_5678, 1'b1, 1'b1);
    idle(1'b1);
    cycle(1'b1, 1'b1, 64'h300, 32'h0BAD_F00D, 1'b1, 1'b0);
    idle(1'b1);

    // Misaligned PC, sticky through flush, cleared by reset
    cycle(1'b1, 1'b1, 64'h40, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h6, 32'h2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    do_reset();

    // Reset mid-operation during simultaneous push and pop
    cycle(1'b1, 1'b1, 64'h500, 32'h5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h504, 32'h6, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'h508, 32'h7, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rpc = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 15) != 0) rpc[1:0] = 2'b00;
      cycle(($urandom_range(0, 99) != 0),
            1'($urandom_range(0, 3) != 0),
            rpc,
            32'($urandom),
            1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_buffer
`default_nettype wire
